// File: rtl/atm_session_ctrl.sv
// ATM user-side session controller: PIN capture, menu, amount entry, retry lockout,
// inactivity timeout, and a single outstanding transaction toward the account core.
module atm_session_ctrl #(
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        card_in,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        txn_valid,
    output logic [1:0]  txn_op,
    output logic [15:0] txn_amount,
    output logic [3:0]  txn_pin,
    input  logic        txn_done,
    input  logic        txn_granted,
    input  logic        txn_success,
    input  logic [15:0] txn_balance,
    output logic [15:0] disp_balance,
    output logic [2:0]  msg,
    output logic        card_locked,
    output logic        eject_card
);

    localparam int unsigned IdleW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned FailW = $clog2(MAX_TRIES + 1);
    localparam logic [IdleW-1:0] IdleLast  = IdleW'(TIMEOUT_CYCLES - 1);
    localparam logic [FailW-1:0] FailLimit = FailW'(MAX_TRIES);

    localparam logic [3:0] KeyEnter    = 4'hA;
    localparam logic [3:0] KeyCancel   = 4'hB;
    localparam logic [3:0] KeyBalance  = 4'hC;
    localparam logic [3:0] KeyDeposit  = 4'hD;
    localparam logic [3:0] KeyWithdraw = 4'hE;
    localparam logic [3:0] KeyClear    = 4'hF;

    localparam logic [2:0] MsgNone     = 3'd0;
    localparam logic [2:0] MsgOk       = 3'd1;
    localparam logic [2:0] MsgDeclined = 3'd2;
    localparam logic [2:0] MsgBadPin   = 3'd3;
    localparam logic [2:0] MsgLocked   = 3'd4;
    localparam logic [2:0] MsgTimeout  = 3'd5;

    typedef enum logic [2:0] {
        StIdle,
        StPin,
        StMenu,
        StAmount,
        StIssue,
        StEject,
        StLocked
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       pin_buf_q, pin_buf_d;
    logic             pin_seen_q, pin_seen_d;
    logic [15:0]      amount_q, amount_d;
    logic [2:0]       digit_cnt_q, digit_cnt_d;
    logic [1:0]       op_q, op_d;
    logic [FailW-1:0] fail_q, fail_d, fail_inc;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [15:0]      disp_q, disp_d;
    logic [2:0]       msg_q, msg_d;
    logic             eject_q, eject_d;
    logic             txn_valid_q, txn_valid_d;
    logic             locked_q, locked_d;
    logic             is_digit;

    // Next-state and next-output computation for the whole session.
    always_comb begin
        state_d     = state_q;
        pin_buf_d   = pin_buf_q;
        pin_seen_d  = pin_seen_q;
        amount_d    = amount_q;
        digit_cnt_d = digit_cnt_q;
        op_d        = op_q;
        fail_d      = fail_q;
        idle_d      = '0;
        disp_d      = disp_q;
        msg_d       = msg_q;
        is_digit    = (key_code <= 4'd9);
        fail_inc    = fail_q + 1'b1;

        case (state_q)
            StIdle: begin
                if (card_in) begin
                    state_d     = StPin;
                    pin_buf_d   = '0;
                    pin_seen_d  = 1'b0;
                    amount_d    = '0;
                    digit_cnt_d = '0;
                    op_d        = '0;
                    fail_d      = '0;
                    msg_d       = MsgNone;
                end
            end
            StPin, StMenu, StAmount: begin
                // Removal beats keys; a key beats timeout expiry.
                if (!card_in) begin
                    state_d = StIdle;
                end else if (key_valid) begin
                    if (state_q == StPin) begin
                        if (is_digit) begin
                            pin_buf_d  = key_code;
                            pin_seen_d = 1'b1;
                        end else if (key_code == KeyEnter && pin_seen_q) begin
                            state_d = StMenu;
                        end else if (key_code == KeyCancel) begin
                            state_d = StEject;
                        end
                    end else if (state_q == StMenu) begin
                        if (key_code == KeyBalance) begin
                            op_d     = 2'b00;
                            amount_d = '0;
                            state_d  = StIssue;
                        end else if (key_code == KeyDeposit || key_code == KeyWithdraw) begin
                            op_d        = (key_code == KeyDeposit) ? 2'b01 : 2'b10;
                            amount_d    = '0;
                            digit_cnt_d = '0;
                            state_d     = StAmount;
                        end else if (key_code == KeyCancel) begin
                            state_d = StEject;
                        end
                    end else begin
                        if (is_digit) begin
                            if (digit_cnt_q < 3'd4) begin
                                amount_d    = amount_q * 16'd10 + {12'd0, key_code};
                                digit_cnt_d = digit_cnt_q + 3'd1;
                            end
                        end else if (key_code == KeyClear) begin
                            amount_d    = '0;
                            digit_cnt_d = '0;
                        end else if (key_code == KeyEnter && amount_q != 16'd0) begin
                            state_d = StIssue;
                        end else if (key_code == KeyCancel) begin
                            state_d = StMenu;
                        end
                    end
                end else if (idle_q == IdleLast) begin
                    state_d = StEject;
                    msg_d   = MsgTimeout;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            StIssue: begin
                if (txn_valid_q && txn_done) begin
                    if (txn_granted) begin
                        fail_d  = '0;
                        disp_d  = txn_balance;
                        msg_d   = txn_success ? MsgOk : MsgDeclined;
                        state_d = card_in ? StMenu : StIdle;
                    end else begin
                        fail_d = fail_inc;
                        if (fail_inc == FailLimit) begin
                            msg_d   = MsgLocked;
                            state_d = StLocked;
                        end else begin
                            msg_d      = MsgBadPin;
                            pin_seen_d = 1'b0;
                            state_d    = card_in ? StPin : StIdle;
                        end
                    end
                end
            end
            StEject: begin
                if (!card_in) begin
                    state_d = StIdle;
                end
            end
            StLocked: begin
                state_d = StLocked;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Any state change restarts the inactivity window.
        if (state_d != state_q) begin
            idle_d = '0;
        end

        eject_d     = (state_d == StEject) && (state_q != StEject);
        txn_valid_d = (state_d == StIssue);
        locked_d    = (state_d == StLocked);
    end

    // Session state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            pin_buf_q   <= '0;
            pin_seen_q  <= 1'b0;
            amount_q    <= '0;
            digit_cnt_q <= '0;
            op_q        <= '0;
            fail_q      <= '0;
            idle_q      <= '0;
            disp_q      <= '0;
            msg_q       <= MsgNone;
            eject_q     <= 1'b0;
            txn_valid_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pin_buf_q   <= pin_buf_d;
            pin_seen_q  <= pin_seen_d;
            amount_q    <= amount_d;
            digit_cnt_q <= digit_cnt_d;
            op_q        <= op_d;
            fail_q      <= fail_d;
            idle_q      <= idle_d;
            disp_q      <= disp_d;
            msg_q       <= msg_d;
            eject_q     <= eject_d;
            txn_valid_q <= txn_valid_d;
            locked_q    <= locked_d;
        end
    end

    assign txn_valid    = txn_valid_q;
    assign txn_op       = op_q;
    assign txn_amount   = amount_q;
    assign txn_pin      = pin_buf_q;
    assign disp_balance = disp_q;
    assign msg          = msg_q;
    assign card_locked  = locked_q;
    assign eject_card   = eject_q;

endmodule

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

User-side session controller for the ATM. It takes single-key events from the keypad and the card-slot sensor, and runs the card session: PIN capture, menu, and decimal amount entry. It also enforces retry lockout and inactivity timeout. It acts as the initiator toward the account core: it issues each transaction (PIN, operation, amount) and consumes the core's granted/success/balance response.

## Interface
Parameters:
- MAX_TRIES, 3: PIN rejections per session before the card is retained.
- TIMEOUT_CYCLES, 1000: idle cycles without a key in PIN/MENU/AMOUNT before ejecting the card.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- card_in  in  1  level; 1 = card present in slot.
- key_valid  in  1  one-cycle strobe qualifying key_code.
- key_code  in  4  0-9 digit, A ENTER, B CANCEL, C BALANCE, D DEPOSIT, E WITHDRAW, F CLEAR.
- txn_valid  out  1  request to account core; held until txn_done.
- txn_op  out  2  00 balance, 01 deposit, 10 withdraw; stable while txn_valid.
- txn_amount  out  16  binary amount; 0 for balance; stable while txn_valid.
- txn_pin  out  4  captured PIN digit; stable while txn_valid.
- txn_done  in  1  one-cycle response strobe from core.
- txn_granted  in  1  PIN accepted; sampled with txn_done.
- txn_success  in  1  transaction completed; sampled with txn_done.
- txn_balance  in  16  post-transaction balance; sampled with txn_done.
- disp_balance  out  16  last balance reported with granted=1.
- msg  out  3  0 NONE, 1 OK, 2 DECLINED, 3 BAD_PIN, 4 LOCKED, 5 TIMEOUT.
- card_locked  out  1  card retained; sticky until reset.
- eject_card  out  1  one-cycle pulse commanding card eject.

## Operation
States are IDLE, PIN, MENU, AMOUNT, ISSUE, EJECT, LOCKED. Reset enters IDLE, clears all outputs, counters and buffers, and sets msg to 0.

- **IDLE**: card_in=1 → PIN; fail_cnt and buffers are cleared on entry.
- **PIN**:
  - Digit: stores into pin_buf (last digit wins) and sets pin_seen.
  - ENTER with pin_seen → MENU. ENTER without pin_seen is ignored.
  - CANCEL → EJECT.
- **MENU**:
  - BALANCE: op=00, amount=0 → ISSUE.
  - DEPOSIT / WITHDRAW: latch op, clear amount_buf → AMOUNT.
  - CANCEL → EJECT.
  - Other keys are ignored.
- **AMOUNT**:
  - Digit d: amount_buf = amount_buf*10 + d, but only while fewer than 4 digits have been entered (max 9999). A 5th digit is ignored.
  - CLEAR: zeroes amount_buf and the digit count.
  - ENTER with amount_buf≠0 → ISSUE. ENTER with amount_buf=0 is ignored.
  - CANCEL → MENU.
- **ISSUE**: txn_valid=1, all keys ignored. On txn_done:
  - granted=1: fail_cnt=0, disp_balance=txn_balance, msg = success ? OK : DECLINED → MENU.
  - granted=0: fail_cnt+1. If the new count equals MAX_TRIES → LOCKED with msg=LOCKED; otherwise → PIN with msg=BAD_PIN and pin_seen cleared.
- **EJECT**: eject_card=1 for exactly one cycle on entry, then wait for card_in=0 → IDLE.
- **LOCKED**: card_locked=1. No eject, keys and card_in are ignored. Only reset exits.
- **Card removal**: card_in=0 in PIN, MENU or AMOUNT → IDLE immediately, with no eject. In ISSUE, removal takes effect after txn_done: the result is recorded as above, then the next state is IDLE instead of MENU/PIN. Lock still wins if reached.
- **Timeout**: in PIN, MENU and AMOUNT, idle_cnt increments each cycle and clears on any key_valid or state change. On idle_cnt reaching TIMEOUT_CYCLES-1 → EJECT with msg=TIMEOUT.
- msg holds its value until the next event that writes it. Entering PIN from IDLE resets msg to 0.

## Timing
- All transitions are registered: a key sampled at edge N takes effect in state and outputs after edge N.
- txn_valid rises one cycle after the accepting ENTER/BALANCE key and falls in the cycle after txn_done is sampled.
- txn_done is honoured only while txn_valid=1; it is ignored otherwise. Minimum ISSUE duration is 1 cycle (done is allowed in the first txn_valid cycle).
- Simultaneous key_valid and card removal: removal wins.
- Simultaneous timeout expiry and key_valid: the key wins, and the counter clears.
- Reset mid-ISSUE: txn_valid drops asynchronously and the core's pending response is discarded.

## Test plan
- Insert card; keys 5, ENTER, BALANCE; core returns done, granted=1, success=1, balance=1000 → txn_op=00, txn_pin=5, disp_balance=1000, msg=OK, state MENU.
- WITHDRAW, keys 1,2,3,4,5, ENTER → txn_amount=1234 (5th digit dropped); respond success=0 → msg=DECLINED, disp_balance updated.
- Three BALANCE requests each answered granted=0 → msg=BAD_PIN twice, then card_locked=1 and msg=LOCKED; no eject_card pulse; further keys ignored until reset.
- PIN entry followed by no keys for TIMEOUT_CYCLES → exactly one eject_card pulse, msg=TIMEOUT; card_in→0 returns to IDLE.
- card_in→0 while txn_valid=1; done arrives 5 cycles later → result recorded, then IDLE, and txn_valid deasserts the cycle after done.
- Assert reset during ISSUE → all outputs 0 immediately, including txn_valid and card_locked.
